// File: rtl/qoi_types_pkg.sv
// qoi_types: shared types for the QOI engine datapath.
//   addr_t        - ping-pong buffer byte address
//   byte_t        - one buffer byte
//   len_t         - byte count, one bit wider than addr_t so a full buffer fits
//   pixel_t       - {r,g,b,a} pixel as handed to the encoder core
//   fetch_state_t - pixel fetch controller states
package qoi_types;

    localparam int ADDR_W = 10;

    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [7:0]             byte_t;
    typedef logic [$bits(addr_t):0] len_t;

    typedef struct packed {
        byte_t r;
        byte_t g;
        byte_t b;
        byte_t a;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_OUT,
        ST_DONE
    } fetch_state_t;

    // Largest multiple of the pixel size that fits in len; the tail beyond it
    // is never read.
    function automatic len_t whole_pixel_bytes(input len_t len, input int channels);
        len_t ch;
        ch = len_t'(channels);
        return len - (len % ch);
    endfunction

endpackage

// File: rtl/qoi_pixel_fetch_assembler.sv
// pixel_assembler: packs a stream of landed read bytes into pixels.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - restart packing at channel 0 (new fetch accepted)
//   byte_vld    - byte_in carries read data this cycle
//   byte_in     - landed read byte
//   take        - the completed pixel is moved downstream this cycle
//   cmp_valid   - a completed pixel is available (landing now or held)
//   cmp_pixel   - the completed pixel; last byte bypasses the register
module pixel_assembler
    import qoi_types::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   byte_vld,
    input  byte_t  byte_in,
    input  logic   take,
    output logic   cmp_valid,
    output pixel_t cmp_pixel
);

    localparam logic [1:0] LAST_CH = 2'(CHANNELS - 1);

    logic [1:0]      chan_q, chan_d;
    logic            full_q, full_d;
    logic [3:0][7:0] lane_q, lane_d;
    logic [3:0][7:0] lane_now;
    logic            land_last;

    assign land_last = byte_vld && (chan_q == LAST_CH);
    // A pixel is complete either as its last byte lands or while it is held
    // because the output register could not accept it.
    assign cmp_valid = full_q || land_last;

    always_comb begin
        chan_d = chan_q;
        full_d = full_q;
        lane_d = lane_q;
        if (byte_vld) begin
            lane_d[chan_q] = byte_in;
            chan_d         = land_last ? 2'd0 : chan_q + 2'd1;
        end
        if (cmp_valid) begin
            full_d = !take;
        end
        if (clr) begin
            chan_d = 2'd0;
            full_d = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_now[k] = (byte_vld && (chan_q == 2'(k))) ? byte_in : lane_q[k];
        end
        cmp_pixel.r = lane_now[0];
        cmp_pixel.g = lane_now[1];
        cmp_pixel.b = lane_now[2];
        // RGB images carry no alpha byte: force it opaque.
        cmp_pixel.a = lane_now[3] | ((CHANNELS == 3) ? 8'hFF : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q <= 2'd0;
            full_q <= 1'b0;
        end else begin
            chan_q <= chan_d;
            full_q <= full_d;
        end
    end

    // Byte lanes are pure data, qualified by chan_q/full_q.
    always_ff @(posedge clk) begin
        lane_q <= lane_d;
    end

endmodule

// File: rtl/qoi_pixel_fetch.sv
// qoi_pixel_fetch: engine-side (port B) pixel fetch from the input buffer.
// On start it reads floor(len/CHANNELS)*CHANNELS bytes from address 0 upward,
// packs them into pixels and streams them to the encoder core.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start, len   - fetch request and byte count (len sampled on accept)
//   addr_b, cs_b, we_b, data_b_o - buffer port B read path (1-cycle latency)
//   pix_valid, pix_ready, pix_data, pix_last - pixel stream to the encoder
//   busy, done   - fetch in progress / one-cycle end-of-fetch pulse
//   err          - len was not a whole number of pixels (sticky per fetch)
module qoi_pixel_fetch
    import qoi_types::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  len_t   len,
    output addr_t  addr_b,
    output logic   cs_b,
    output logic   we_b,
    input  byte_t  data_b_o,
    output logic   pix_valid,
    input  logic   pix_ready,
    output pixel_t pix_data,
    output logic   pix_last,
    output logic   busy,
    output logic   done,
    output logic   err
);

    localparam len_t CH_LEN = len_t'(CHANNELS);

    fetch_state_t state_q, state_d;
    addr_t        addr_q, addr_d;
    len_t         left_q, left_d;
    logic         rd_pend_q;
    logic         out_valid_q, out_valid_d;
    pixel_t       out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         err_q, err_d;

    len_t         whole;
    logic         clr;
    logic         cmp_valid;
    pixel_t       cmp_pixel;
    logic         out_free;
    logic         take;
    logic         blocked;
    logic         last_hs;

    assign whole    = whole_pixel_bytes(len, CHANNELS);
    assign clr      = (state_q == ST_IDLE) && start;

    // Output register can load when empty or being drained this cycle.
    assign out_free = !out_valid_q || pix_ready;
    assign take     = cmp_valid && out_free;
    assign blocked  = cmp_valid && !out_free;
    assign last_hs  = out_valid_q && out_last_q && pix_ready;

    // Reads stop in the very cycle a completed pixel is blocked, so at most
    // one pixel ever waits in assembly and nothing lands behind it.
    assign cs_b     = (state_q == ST_FETCH) && (left_q != '0) && !blocked;

    pixel_assembler #(
        .CHANNELS (CHANNELS)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .byte_vld  (rd_pend_q),
        .byte_in   (data_b_o),
        .take      (take),
        .cmp_valid (cmp_valid),
        .cmp_pixel (cmp_pixel)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        if (cs_b) begin
            left_d = left_q - len_t'(1);
            // Hold at the final address so a full buffer ends at all-ones.
            if (left_q != len_t'(1)) begin
                addr_d = addr_q + addr_t'(1);
            end
        end

        // A pixel completed when no reads remain is the final one.
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = cmp_pixel;
            out_last_d  = (left_q == '0);
        end else if (pix_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = (whole != len);
                    left_d  = whole;
                    addr_d  = '0;
                    state_d = (len >= CH_LEN) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (last_hs) begin
                    state_d = ST_DONE;
                end else if (blocked) begin
                    state_d = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                if (last_hs) begin
                    state_d = ST_DONE;
                end else if (take) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            rd_pend_q   <= cs_b;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign addr_b    = addr_q;
    assign we_b      = 1'b0;
    assign pix_valid = out_valid_q;
    assign pix_data  = out_data_q;
    assign pix_last  = out_last_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_WAIT_OUT);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: doc/qoi_pixel_fetch.md
# qoi_pixel_fetch

Pixel fetch stage on the engine side (port B) of the ping-pong buffer memory. On a start pulse it reads a byte image from the input buffer, packs consecutive bytes into RGB/RGBA pixels, and presents them to the QOI encoder core over a valid/ready stream. It owns only the port-B read path. The buffer-select line is driven elsewhere and is held in the engine-owns-input-buffer position for the whole fetch.

## Interface
Parameters:
- CHANNELS, 4: bytes per pixel; legal values 3 (RGB) or 4 (RGBA).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a fetch; ignored while busy.
- len  in  len_t  byte count to fetch; sampled only when start is accepted.
- addr_b  out  addr_t  buffer read address.
- cs_b  out  1  read strobe.
- we_b  out  1  tied 0.
- data_b_o  in  byte_t  read data, valid the cycle after cs_b.
- pix_valid  out  1  pix_data holds a pixel.
- pix_ready  in  1  consumer accepts the pixel when high together with pix_valid.
- pix_data  out  pixel_t  {r,g,b,a}; a=8'hFF when CHANNELS=3.
- pix_last  out  1  qualifies the final pixel of the fetch.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse at the end of a fetch.
- err  out  1  sticky until the next accepted start; len was not a multiple of CHANNELS.

## Operation
- States:
  - IDLE -> FETCH on start with len>=CHANNELS.
  - IDLE -> DONE on start with len<CHANNELS; no reads are issued.
  - FETCH -> WAIT_OUT when a completed pixel cannot leave assembly.
  - WAIT_OUT -> FETCH when the output register drains.
  - FETCH/WAIT_OUT -> DONE on the final handshake.
  - DONE -> IDLE.
- The number of bytes read is floor(len/CHANNELS)*CHANNELS. Trailing bytes are never read, and err is set for that fetch.
- Byte k of a pixel goes into channel k (r,g,b,a order). Byte address counter starts at 0 and increments by 1 per issued read.
- There is an assembly register and a one-entry output register. A completed pixel moves to the output register on the edge its last byte lands, if the output register is empty or being accepted that cycle.
- If that move is blocked:
  - assembly holds the pixel;
  - cs_b is deasserted in that same cycle (combinational from pix_ready);
  - the FSM enters WAIT_OUT, and no reads are issued until the move occurs.
- No byte is dropped or duplicated, and pixel order is preserved.
- pix_last is set on the pixel built from the final fetched bytes.
- done pulses in the cycle after that pixel's handshake, or in the cycle after start for short lengths. busy falls in that same cycle.
- Reset values: addr_b=0, cs_b=0, we_b=0, pix_valid=0, pix_data=0, pix_last=0, busy=0, done=0, err=0, state IDLE.
- Asserting rst_n low mid-fetch clears all outputs immediately and abandons the fetch, with no done.

## Timing
- Start is sampled in cycle 0. busy is high from cycle 1, and cs_b with addr_b=0 is also in cycle 1.
- Read latency is 1 cycle. data_b_o for the read issued in cycle t is captured at the end of cycle t+1.
- Sustained throughput is one byte read per cycle, so one pixel per CHANNELS cycles, with no bubbles while pix_ready stays high.
- First pixel: pix_valid goes high in cycle CHANNELS+2.
- A full buffer (len = 2**$bits(addr_t)) ends at address all-ones. The address does not wrap beyond it and no extra read is issued.

## Structure
- qoi_types package:
  - add typedef pixel_t (struct of four byte_t: r,g,b,a);
  - add typedef len_t, logic [$bits(addr_t):0];
  - add the FSM state enum.
- Reuse the existing addr_t and byte_t.
- Single module; an optional sub-module pixel_assembler (byte-to-pixel packing plus the channel counter) is natural.

## Test plan
- CHANNELS=4, len=8, memory 01..08, pix_ready=1 -> pixels:
  - {01,02,03,04} valid in cycle 6;
  - {05,06,07,08} with pix_last in cycle 10;
  - done in cycle 11; 8 reads total.
- CHANNELS=4, len=12, pix_ready low in cycles 6-12 -> addr 8 not issued while stalled; on pix_ready high, three pixels emerge in order with no byte lost.
- CHANNELS=3, len=6, bytes 10..15 -> pixels {10,11,12,FF} and {13,14,15,FF}; err=0.
- len=0 -> done in cycle 1, cs_b never high. len=6 with CHANNELS=4 -> one pixel, last address read is 3, err=1.
- len=2**$bits(addr_t) -> final read at address all-ones, pix_last on the final pixel, no wrap read.
- rst_n low mid-FETCH -> cs_b, pix_valid and busy drop at once. A start pulse asserted while busy is ignored.
